dp_sequencer: RTL
=================

DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 SHALL have parameter NV_EXECUTES, default 0, meaning: 1 = cond 4'b1111 executes like AL, 0 = cond 4'b1111 fails.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  instruction valid; sampled only in IDLE.
REQ-005 SHALL have port ir  in  32  ARM data-processing instruction word.
REQ-006 SHALL have port nzcv  in  4  current flags {N,Z,C,V} from the ALU stage.
REQ-007 SHALL have ports rn_addr, rm_addr, rs_addr, rd_addr  out  4 each  register-file addresses.
REQ-008 SHALL have port imm_sel  out  1  Shift_Data source select: 1 = imm_data, 0 = Rm.
REQ-009 SHALL have port imm_data  out  32  zero-extended imm8.
REQ-010 SHALL have port shift_reg_sel  out  1  Shift_Num source select: 1 = Rs[7:0], 0 = shift_imm.
REQ-011 SHALL have port shift_imm  out  8  immediate shift amount.
REQ-012 SHALL have port SHIFT_OP  out  3  bits [2:1]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; bit [0]: 1 = register-specified count.
REQ-013 SHALL have port ALU_OP  out  4  equal to ir[24:21].
REQ-014 SHALL have port S  out  1  flag-latch strobe; the consumer latches on its rising edge.
REQ-015 SHALL have ports wr_en, busy, done, skipped  out  1 each.

Function
REQ-016 SHALL implement states IDLE, DECODE, EXEC, WB.
REQ-017 SHALL, in IDLE with start=1, capture ir into an internal register and go to DECODE; start SHALL be ignored in every other state.
REQ-018 SHALL, in DECODE, evaluate ir[31:28] against nzcv:
- EQ..LE per ARM semantics.
- AL passes.
- 4'b1111 handled per NV_EXECUTES.
- Pass -> EXEC; fail -> WB with an internal skip flag set.
REQ-019 SHALL go EXEC -> WB -> IDLE unconditionally.
REQ-020 SHALL decode the captured ir, holding all address and control outputs stable from DECODE through WB:
- rn = ir[19:16], rd = ir[15:12], rm = ir[3:0], rs = ir[11:8].
REQ-021 SHALL, when I = ir[25] = 1, drive:
- imm_sel = 1, imm_data = {24'b0, ir[7:0]}.
- shift_imm = {3'b0, ir[11:8], 1'b0}.
- SHIFT_OP = 3'b110, shift_reg_sel = 0.
REQ-022 SHALL, when I = 0 and ir[4] = 0, drive SHIFT_OP = {ir[6:5], 0}, shift_imm = {3'b0, ir[11:7]}, shift_reg_sel = 0.
REQ-023 SHALL, when I = 0 and ir[4] = 1, drive SHIFT_OP = {ir[6:5], 1} and shift_reg_sel = 1.
REQ-024 SHALL treat opcodes 10xx (TST, TEQ, CMP, CMN) as compare ops: flags always updated, no register write.
REQ-025 SHALL, in WB with skip clear, drive S = 1 if ir[20] = 1 or the op is a compare, and wr_en = 1 if the op is not a compare.
REQ-026 SHALL hold S and wr_en at 0 in every state other than WB, and in WB when the skip flag is set.
REQ-027 SHALL drive done = 1 exactly in WB, and skipped = 1 in WB only when the skip flag is set.
REQ-028 SHALL drive busy = 1 in every state except IDLE.
REQ-029 SHALL have latency, measured from the start edge T0: DECODE at T1, EXEC at T2, WB (done) at T3; a skipped instruction reaches WB at T2.
REQ-030 SHALL accept a start asserted in the cycle after WB (back-to-back); it is sampled in IDLE.

Reset
REQ-031 SHALL, while rst_n = 0, immediately force:
- state IDLE, internal ir register and skip flag 0.
- every output 0, including S, wr_en, done, busy, skipped and SHIFT_OP.
REQ-032 SHALL abandon an instruction in flight when reset is asserted: no S, wr_en or done is produced for it after release.

Verification
REQ-033 SHALL be verified with ADD r1,r2,r3, ir = 0xE0821003, nzcv = 0 -> ALU_OP 0100, rn 2, rm 3, rd 1, SHIFT_OP 000, shift_imm 0; at T3 wr_en = 1, S = 0, done = 1.
REQ-034 SHALL be verified with MOVS r0,#0xFF000000, ir = 0xE3B004FF -> imm_sel 1, imm_data 0x000000FF, shift_imm 8, SHIFT_OP 110, ALU_OP 1101; at T3 S = 1, wr_en = 1.
REQ-035 SHALL be verified with CMP r1,r2, ir = 0xE1510002 -> ALU_OP 1010; at T3 S = 1, wr_en = 0.
REQ-036 SHALL be verified with ADDEQ, ir = 0x00821003, nzcv = 0000 -> at T2 done = 1, skipped = 1, S = 0, wr_en = 0; IDLE at T3.
REQ-037 SHALL be verified with ADD r1,r2,r3,LSL r4, ir = 0xE0821413 -> SHIFT_OP 001, rs_addr 4, shift_reg_sel 1.
REQ-038 SHALL be verified with rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no done afterwards, and a new start accepted normally.

Source files
------------

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions: captures an
// instruction, evaluates its condition field, and drives decode/control signals.
module dp_sequencer #(
    parameter int NV_EXECUTES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [3:0]  nzcv,
    output logic [3:0]  rn_addr,
    output logic [3:0]  rm_addr,
    output logic [3:0]  rs_addr,
    output logic [3:0]  rd_addr,
    output logic        imm_sel,
    output logic [31:0] imm_data,
    output logic        shift_reg_sel,
    output logic [7:0]  shift_imm,
    output logic [2:0]  SHIFT_OP,
    output logic [3:0]  ALU_OP,
    output logic        S,
    output logic        wr_en,
    output logic        busy,
    output logic        done,
    output logic        skipped,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] ir_q;
    logic        skip_q;
    logic        cond_pass;
    logic        is_cmp;
    logic        unused_ir_bits;

    // Handshake: start is a valid strobe, and !busy acts as ready; a start
    // is taken only on an edge where the FSM sits in IDLE, otherwise dropped.
    logic accept;
    assign accept = (state == IDLE) && start;

    assign is_cmp         = (ir_q[24:23] == 2'b10);
    assign unused_ir_bits = ^ir_q[27:26];

    always_comb begin
        cond_pass = 1'b0;
        case (ir_q[31:28])
            4'h0: cond_pass = nzcv[2];
            4'h1: cond_pass = !nzcv[2];
            4'h2: cond_pass = nzcv[1];
            4'h3: cond_pass = !nzcv[1];
            4'h4: cond_pass = nzcv[3];
            4'h5: cond_pass = !nzcv[3];
            4'h6: cond_pass = nzcv[0];
            4'h7: cond_pass = !nzcv[0];
            4'h8: cond_pass = nzcv[1] && !nzcv[2];
            4'h9: cond_pass = !nzcv[1] || nzcv[2];
            4'hA: cond_pass = (nzcv[3] == nzcv[0]);
            4'hB: cond_pass = (nzcv[3] != nzcv[0]);
            4'hC: cond_pass = !nzcv[2] && (nzcv[3] == nzcv[0]);
            4'hD: cond_pass = nzcv[2] || (nzcv[3] != nzcv[0]);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = (NV_EXECUTES != 0);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= 32'd0;
            skip_q <= 1'b0;
        end else if (accept) begin
            ir_q   <= ir;
            skip_q <= 1'b0;
        end else if (state == DECODE) begin
            skip_q <= !cond_pass;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DECODE;
            DECODE:  state_nxt = cond_pass ? EXEC : WB;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode outputs are driven only while busy so IDLE presents all zeros.
    always_comb begin
        rn_addr       = 4'd0;
        rm_addr       = 4'd0;
        rs_addr       = 4'd0;
        rd_addr       = 4'd0;
        imm_sel       = 1'b0;
        imm_data      = 32'd0;
        shift_reg_sel = 1'b0;
        shift_imm     = 8'd0;
        SHIFT_OP      = 3'b000;
        ALU_OP        = 4'd0;
        S             = 1'b0;
        wr_en         = 1'b0;
        busy          = (state != IDLE);
        done          = (state == WB);
        skipped       = (state == WB) && skip_q;
        dbg_state     = state;
        if (state != IDLE) begin
            rn_addr = ir_q[19:16];
            rd_addr = ir_q[15:12];
            rs_addr = ir_q[11:8];
            rm_addr = ir_q[3:0];
            ALU_OP  = ir_q[24:21];
            if (ir_q[25]) begin
                imm_sel   = 1'b1;
                imm_data  = {24'd0, ir_q[7:0]};
                shift_imm = {3'b000, ir_q[11:8], 1'b0};
                SHIFT_OP  = 3'b110;
            end else if (!ir_q[4]) begin
                SHIFT_OP  = {ir_q[6:5], 1'b0};
                shift_imm = {3'b000, ir_q[11:7]};
            end else begin
                SHIFT_OP      = {ir_q[6:5], 1'b1};
                shift_reg_sel = 1'b1;
            end
        end
        if ((state == WB) && !skip_q) begin
            S     = ir_q[20] || is_cmp;
            wr_en = !is_cmp;
        end
    end

endmodule
